anita_l1l2_trigger_n: RTL and testbench

- Parametrised successor to the fixed 2-sector ANITA-4 dual-L1 trigger.
- Handles NSECT phi sectors × NRING rings of LCP/RCP tunnel-diode channels, all in one clock domain.
- Per channel: forms L1 as an LCP/RCP coincidence within a programmable window. Per sector: forms L2 as a multi-ring majority.
- Drives per-sector TURF trigger pulses with holdoff, plus gated saturating L1/L2 scalers.
- Sits after the trigger map. Inputs are already synchronous to clk_i.

---
 rtl/anita_l1l2_trigger_n.sv | 219 +++++++++++++++++++++
 tb/tb_anita_l1l2_trigger_n.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/anita_l1l2_trigger_n.sv
// ANITA L1 (LCP/RCP coincidence) / L2 (multi-ring majority) sector trigger with scalers.
// Optional raw-edge L0 scalers are built when ANITA_L0_SCALER_EN is defined.
module anita_l1l2_trigger_n #(
   parameter int NSECT     = 2,
   parameter int NRING     = 3,
   parameter int WINDOW    = 4,
   parameter int L2_WINDOW = 8,
   parameter int L2_MIN    = 2,
   parameter int TRIG_LEN  = 4,
   parameter int HOLDOFF   = 16,
   parameter int SCAL_W    = 16,
   localparam int NCH      = NRING*NSECT
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NCH-1:0]            lcp_i,
   input  logic [NCH-1:0]            rcp_i,
   input  logic [NCH-1:0]            mask_i,
   input  logic [NCH-1:0]            force_i,
   input  logic                      scal_gate_i,
   output logic [NSECT-1:0]          trig_o,
   output logic [NCH-1:0]            l1_o,
   output logic [NCH*SCAL_W-1:0]     scal_l1_o,
   output logic [NSECT*SCAL_W-1:0]   scal_l2_o,
`ifdef ANITA_L0_SCALER_EN
   output logic [2*NCH*SCAL_W-1:0]   scal_l0_o,
`endif
   output logic                      scal_valid_o
);

   localparam logic [3:0] WIN_LOAD = 4'(WINDOW);
   localparam logic [3:0] L2_LOAD  = 4'(L2_WINDOW-1);
   localparam int TMAX      = (TRIG_LEN > HOLDOFF) ? TRIG_LEN : HOLDOFF;
   localparam int CW        = $clog2(TMAX+1);
   localparam int HOLD_LOAD = (HOLDOFF > 0) ? HOLDOFF-1 : 0;

   typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

   function automatic logic [3:0] win_step(input logic ld, input logic [3:0] load,
                                           input logic [3:0] cur);
      if (ld) return load;
      if (cur != 4'd0) return cur - 4'd1;
      return cur;
   endfunction

   function automatic logic [SCAL_W-1:0] sat_inc(input logic [SCAL_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [NCH-1:0]    lcp_q, rcp_q, mask_q, force_q, l1_lvl_q;
   logic [NCH-1:0]    lcp_edge, rcp_edge, lcp_open, rcp_open, l1_lvl, l1_open;
   logic [3:0]        lcp_win [NCH];
   logic [3:0]        rcp_win [NCH];
   logic [3:0]        l2_win  [NCH];
   logic [NRING-1:0]  ring_vec [NSECT];
   logic [NSECT-1:0]  l2_lvl, l2_lvl_q, fire_evt;
   state_t            state_q [NSECT];
   state_t            state_d [NSECT];
   logic [CW-1:0]     tcnt_q  [NSECT];
   logic [CW-1:0]     tcnt_d  [NSECT];
   logic [SCAL_W-1:0] l1_scal [NCH];
   logic [SCAL_W-1:0] l2_scal [NSECT];

   always_comb begin
      lcp_edge = lcp_i & ~lcp_q;
      rcp_edge = rcp_i & ~rcp_q;
      lcp_open = '0;
      rcp_open = '0;
      l1_open  = '0;
      for (int c = 0; c < NCH; c++) begin
         lcp_open[c] = (lcp_win[c] != 4'd0);
         rcp_open[c] = (rcp_win[c] != 4'd0);
         // The L2 window includes the l1_o cycle itself, hence the load of L2_WINDOW-1.
         l1_open[c]  = l1_o[c] | (l2_win[c] != 4'd0);
      end
      l1_lvl = (lcp_open & rcp_open & ~mask_q) | force_q;
      l2_lvl = '0;
      for (int s = 0; s < NSECT; s++) begin
         ring_vec[s] = '0;
         for (int r = 0; r < NRING; r++) ring_vec[s][r] = l1_open[r*NSECT+s];
         l2_lvl[s] = ($countones(ring_vec[s]) >= L2_MIN);
      end
   end

   // Stage: input history, window counters, registered L1 level and pulse, L2 level
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lcp_q    <= '0;
         rcp_q    <= '0;
         mask_q   <= '0;
         force_q  <= '0;
         l1_lvl_q <= '0;
         l1_o     <= '0;
         l2_lvl_q <= '0;
         for (int c = 0; c < NCH; c++) begin
            lcp_win[c] <= '0;
            rcp_win[c] <= '0;
            l2_win[c]  <= '0;
         end
      end else begin
         lcp_q    <= lcp_i;
         rcp_q    <= rcp_i;
         mask_q   <= mask_i;
         force_q  <= force_i;
         l1_lvl_q <= l1_lvl;
         l1_o     <= l1_lvl & ~l1_lvl_q;
         l2_lvl_q <= l2_lvl;
         for (int c = 0; c < NCH; c++) begin
            lcp_win[c] <= win_step(lcp_edge[c], WIN_LOAD, lcp_win[c]);
            rcp_win[c] <= win_step(rcp_edge[c], WIN_LOAD, rcp_win[c]);
            l2_win[c]  <= win_step(l1_o[c], L2_LOAD, l2_win[c]);
         end
      end
   end

   // Stage: per-sector trigger FSM
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < NSECT; s++) begin
            state_q[s] <= IDLE;
            tcnt_q[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < NSECT; s++) begin
            state_q[s] <= state_d[s];
            tcnt_q[s]  <= tcnt_d[s];
         end
      end
   end

   always_comb begin
      fire_evt = '0;
      trig_o   = '0;
      for (int s = 0; s < NSECT; s++) begin
         state_d[s] = state_q[s];
         tcnt_d[s]  = tcnt_q[s];
         case (state_q[s])
            IDLE: begin
               if (l2_lvl_q[s]) begin
                  state_d[s]  = FIRE;
                  tcnt_d[s]   = CW'(TRIG_LEN-1);
                  fire_evt[s] = 1'b1;
               end
            end
            FIRE: begin
               if (tcnt_q[s] == '0) begin
                  if (HOLDOFF == 0) begin
                     state_d[s] = IDLE;
                  end else begin
                     state_d[s] = HOLD;
                     tcnt_d[s]  = CW'(HOLD_LOAD);
                  end
               end else begin
                  tcnt_d[s] = tcnt_q[s] - 1'b1;
               end
            end
            HOLD: begin
               if (tcnt_q[s] == '0) state_d[s] = IDLE;
               else                 tcnt_d[s] = tcnt_q[s] - 1'b1;
            end
            default: state_d[s] = IDLE;
         endcase
         trig_o[s] = (state_q[s] == FIRE);
      end
   end

   // Stage: gated saturating scalers; an event in the gate cycle starts the new period at 1
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         scal_l1_o    <= '0;
         scal_l2_o    <= '0;
         scal_valid_o <= 1'b0;
         for (int c = 0; c < NCH; c++)   l1_scal[c] <= '0;
         for (int s = 0; s < NSECT; s++) l2_scal[s] <= '0;
      end else begin
         scal_valid_o <= scal_gate_i;
         for (int c = 0; c < NCH; c++) begin
            if (scal_gate_i) begin
               scal_l1_o[c*SCAL_W +: SCAL_W] <= l1_scal[c];
               l1_scal[c] <= SCAL_W'(l1_o[c]);
            end else if (l1_o[c]) begin
               l1_scal[c] <= sat_inc(l1_scal[c]);
            end
         end
         for (int s = 0; s < NSECT; s++) begin
            if (scal_gate_i) begin
               scal_l2_o[s*SCAL_W +: SCAL_W] <= l2_scal[s];
               l2_scal[s] <= SCAL_W'(fire_evt[s]);
            end else if (fire_evt[s]) begin
               l2_scal[s] <= sat_inc(l2_scal[s]);
            end
         end
      end
   end

`ifdef ANITA_L0_SCALER_EN
   logic [SCAL_W-1:0] l0_scal [2*NCH];
   logic [2*NCH-1:0]  l0_evt;

   assign l0_evt = {rcp_edge, lcp_edge};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         scal_l0_o <= '0;
         for (int c = 0; c < 2*NCH; c++) l0_scal[c] <= '0;
      end else begin
         for (int c = 0; c < 2*NCH; c++) begin
            if (scal_gate_i) begin
               scal_l0_o[c*SCAL_W +: SCAL_W] <= l0_scal[c];
               l0_scal[c] <= SCAL_W'(l0_evt[c]);
            end else if (l0_evt[c]) begin
               l0_scal[c] <= sat_inc(l0_scal[c]);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_anita_l1l2_trigger_n.sv
// Directed bench for anita_l1l2_trigger_n: default trigger parameters, 4-bit scalers.
module tb_anita_l1l2_trigger_n;
   localparam int NSECT = 2;
   localparam int NCH   = 6;
   localparam int SW    = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    lcp, rcp, mask, force_r;
   logic              scal_gate;
   logic [NSECT-1:0]  trig;
   logic [NCH-1:0]    l1;
   logic [NCH*SW-1:0] scal_l1;
   logic [NSECT*SW-1:0] scal_l2;
   logic              scal_valid;
`ifdef ANITA_L0_SCALER_EN
   logic [2*NCH*SW-1:0] scal_l0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   anita_l1l2_trigger_n #(.SCAL_W(SW)) dut (
      .clk_i(clk), .rst_i(rst), .lcp_i(lcp), .rcp_i(rcp), .mask_i(mask),
      .force_i(force_r), .scal_gate_i(scal_gate), .trig_o(trig), .l1_o(l1),
      .scal_l1_o(scal_l1), .scal_l2_o(scal_l2),
`ifdef ANITA_L0_SCALER_EN
      .scal_l0_o(scal_l0),
`endif
      .scal_valid_o(scal_valid));

   always #2 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic gate();
      scal_gate = 1'b1;
      tick();
      scal_gate = 1'b0;
      chk("valid_hi", 32'(scal_valid), 32'd1);
   endtask

   initial begin
      rst = 1'b1; lcp = '0; rcp = '0; mask = '0; force_r = '0; scal_gate = 1'b0;
      idle(3);
      chk("rst_trig", 32'(trig), 32'd0);
      chk("rst_l1", 32'(l1), 32'd0);
      chk("rst_scal_l1", 32'(scal_l1), 32'd0);
      chk("rst_scal_l2", 32'(scal_l2), 32'd0);
      chk("rst_valid", 32'(scal_valid), 32'd0);
      rst = 1'b0;
      idle(5);

      // Edges 3 apart coincide, l1 two cycles after the second edge
      for (int k = 0; k < 10; k++) begin
         lcp[0] = (k == 0); rcp[0] = (k == 3);
         chk("l1_sep3", 32'(l1[0]), 32'(k == 5));
         chk("trig_1ring", 32'(trig), 32'd0);
         tick();
      end
      idle(6);
      for (int k = 0; k < 10; k++) begin
         lcp[0] = (k == 0); rcp[0] = (k == 4);
         chk("l1_sep4", 32'(l1[0]), 32'd0);
         tick();
      end
      idle(10);

      // Two-ring L2 in sector 0, a retrigger inside HOLD, and one after re-arm
      gate();
      for (int k = 0; k < 46; k++) begin
         lcp[0] = (k == 0 || k == 13 || k == 30); rcp[0] = lcp[0];
         lcp[2] = (k == 3 || k == 13 || k == 30); rcp[2] = lcp[2];
         chk("trig0", 32'(trig[0]), 32'((k >= 7 && k <= 10) || (k >= 34 && k <= 37)));
         chk("trig1", 32'(trig[1]), 32'd0);
         tick();
      end
      gate();
      chk("scal_l2_cnt", 32'(scal_l2), 32'h02);
      chk("scal_l1_cnt", 32'(scal_l1), 32'h000303);
      idle(20);

      // Mask blocks L1; force overrides mask and gives a single pulse
      mask[0] = 1'b1;
      tick();
      for (int k = 0; k < 9; k++) begin
         lcp[0] = (k == 0); rcp[0] = (k == 0);
         chk("l1_mask", 32'(l1[0]), 32'd0);
         tick();
      end
      gate();
      for (int k = 0; k < 9; k++) begin
         force_r[0] = 1'b1;
         chk("l1_force", 32'(l1[0]), 32'(k == 2));
         tick();
      end
      gate();
      chk("force_per1", 32'(scal_l1[3:0]), 32'd1);
      gate();
      chk("force_per2", 32'(scal_l1[3:0]), 32'd0);
      force_r = '0; mask = '0;
      idle(10);

      // Saturation of a 4-bit scaler and the gate-cycle event rule
      gate();
      for (int i = 0; i < 20; i++) begin
         lcp[1] = 1'b1; rcp[1] = 1'b1;
         tick();
         lcp[1] = 1'b0; rcp[1] = 1'b0;
         idle(5);
      end
      gate();
      chk("scal_sat", 32'(scal_l1[7:4]), 32'd15);
      lcp[1] = 1'b1; rcp[1] = 1'b1;
      tick();
      lcp[1] = 1'b0; rcp[1] = 1'b0;
      tick();
      chk("l1_gatecyc", 32'(l1[1]), 32'd1);
      gate();
      chk("gate_prev", 32'(scal_l1[7:4]), 32'd0);
      gate();
      chk("gate_new", 32'(scal_l1[7:4]), 32'd1);
      tick();
      chk("valid_lo", 32'(scal_valid), 32'd0);
      idle(10);

      // Asynchronous reset during FIRE, then normal trigger after release
      lcp[0] = 1'b1; rcp[0] = 1'b1; lcp[2] = 1'b1; rcp[2] = 1'b1;
      tick();
      lcp = '0; rcp = '0;
      idle(3);
      chk("trig_pre_rst", 32'(trig[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("trig_rst", 32'(trig), 32'd0);
      chk("scal_rst", 32'(scal_l1), 32'd0);
      idle(2);
      rst = 1'b0;
      idle(3);
      for (int k = 0; k < 11; k++) begin
         lcp[0] = (k == 0); rcp[0] = lcp[0]; lcp[2] = lcp[0]; rcp[2] = lcp[0];
         chk("trig_post", 32'(trig[0]), 32'(k >= 4 && k <= 7));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
